// File: rtl/riscv_structures_pkg.sv
// Shared pipeline bundle types, MEM-stage FSM encoding and LSU defaults.
package riscv_structures;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic        mem_write;
    logic        reg_write;
    logic [4:0]  rd;
    logic        mem_read;
  } ex_to_mem_s;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        reg_write;
  } mem_to_wb_s;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} mem_state_e;

  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned TIMER_W = 10;

endpackage

// File: rtl/lsu_timer.sv
// Saturating access timer: counts while enabled, holds at LIMIT-1 and flags expiry.
module lsu_timer #(
  parameter int unsigned W     = 10,
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mem_stage.sv
// MEM stage: word loads/stores over a req/gnt/rvalid bus, stalling upstream until done.
module mem_stage
  import riscv_structures::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT,
  parameter bit          CHECK_ALIGN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  ex_to_mem_s  ex_to_mem,
  output logic        stall_o,
  output logic [31:0] bp_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output mem_to_wb_s  mem_to_wb,
  output logic        misalign_err,
  output logic        bus_err
);

  mem_state_e  state, state_n;
  mem_to_wb_s  wb_n;
  logic [31:2] lat_addr;
  logic        lat_we;
  logic [31:0] lat_wdata;
  logic [4:0]  lat_rd;
  logic        latch, mis_set, bus_set;
  logic        access, misaligned, timer_expired;

  lsu_timer #(
    .W     (TIMER_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == IDLE),
    .en      (state != IDLE),
    .expired (timer_expired)
  );

  assign bp_mem     = ex_to_mem.alu_result;
  assign access     = ex_to_mem.mem_write | (ex_to_mem.mem_read & ex_to_mem.reg_write);
  assign misaligned = CHECK_ALIGN && (ex_to_mem.alu_result[1:0] != 2'b00);

  always_comb begin
    state_n    = state;
    stall_o    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = lat_we;
    dmem_addr  = {lat_addr, 2'b00};
    dmem_wdata = lat_wdata;
    wb_n       = '0;
    latch      = 1'b0;
    mis_set    = 1'b0;
    bus_set    = 1'b0;
    unique case (state)
      IDLE: begin
        dmem_we    = ex_to_mem.mem_write;
        dmem_addr  = {ex_to_mem.alu_result[31:2], 2'b00};
        dmem_wdata = ex_to_mem.write_data;
        if (!access) begin
          wb_n = '{result: ex_to_mem.alu_result, rd: ex_to_mem.rd, reg_write: ex_to_mem.reg_write};
        end else if (misaligned) begin
          mis_set = 1'b1;
          wb_n    = '{result: '0, rd: ex_to_mem.rd, reg_write: !ex_to_mem.mem_write};
        end else begin
          dmem_req = 1'b1;
          if (!(dmem_gnt && ex_to_mem.mem_write)) begin
            stall_o = 1'b1;
            latch   = 1'b1;
            state_n = dmem_gnt ? DATA : ADDR;
          end
        end
      end
      ADDR: begin
        dmem_req = 1'b1;
        stall_o  = 1'b1;
        if (dmem_gnt) begin
          if (lat_we) begin
            stall_o = 1'b0;
            state_n = IDLE;
          end else begin
            state_n = DATA;
          end
        end else if (timer_expired) begin
          stall_o = 1'b0;
          bus_set = 1'b1;
          state_n = IDLE;
          wb_n    = '{result: '0, rd: lat_rd, reg_write: !lat_we};
        end
      end
      DATA: begin
        stall_o = 1'b1;
        if (dmem_rvalid) begin
          stall_o = 1'b0;
          state_n = IDLE;
          wb_n    = '{result: dmem_rdata, rd: lat_rd, reg_write: 1'b1};
        end else if (timer_expired) begin
          stall_o = 1'b0;
          bus_set = 1'b1;
          state_n = IDLE;
          wb_n    = '{result: '0, rd: lat_rd, reg_write: 1'b1};
        end
      end
      default: state_n = IDLE;
    endcase
    if (rst) dmem_req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mem_to_wb    <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      lat_addr     <= '0;
      lat_we       <= 1'b0;
      lat_wdata    <= '0;
      lat_rd       <= '0;
    end else begin
      state     <= state_n;
      mem_to_wb <= wb_n;
      if (mis_set) misalign_err <= 1'b1;
      if (bus_set) bus_err <= 1'b1;
      if (latch) begin
        lat_addr  <= ex_to_mem.alu_result[31:2];
        lat_we    <= ex_to_mem.mem_write;
        lat_wdata <= ex_to_mem.write_data;
        lat_rd    <= ex_to_mem.rd;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a short access timeout.
module tb_mem_stage;
  import riscv_structures::*;

  logic        clk = 1'b0;
  logic        rst;
  ex_to_mem_s  ex;
  logic        stall_o;
  logic [31:0] bp_mem;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  mem_to_wb_s  mem_to_wb;
  logic        misalign_err, bus_err;

  int checks   = 0;
  int failures = 0;

  mem_stage #(.TIMEOUT_CYCLES(4), .CHECK_ALIGN(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_to_mem    (ex),
    .stall_o      (stall_o),
    .bp_mem       (bp_mem),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .mem_to_wb    (mem_to_wb),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] wb(input logic [31:0] r, input logic [4:0] rd, input logic rw);
    return 64'({r, rd, rw});
  endfunction

  task automatic set_nop();
    ex = '0;
  endtask

  task automatic set_alu(input logic [31:0] r, input logic [4:0] rd);
    ex = '{alu_result: r, write_data: '0, mem_write: 1'b0, reg_write: 1'b1, rd: rd, mem_read: 1'b0};
  endtask

  task automatic set_ld(input logic [31:0] a, input logic [4:0] rd);
    ex = '{alu_result: a, write_data: '0, mem_write: 1'b0, reg_write: 1'b1, rd: rd, mem_read: 1'b1};
  endtask

  task automatic set_st(input logic [31:0] a, input logic [31:0] d);
    ex = '{alu_result: a, write_data: d, mem_write: 1'b1, reg_write: 1'b0, rd: 5'd0, mem_read: 1'b0};
  endtask

  initial begin
    rst = 1'b1; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    set_nop();
    tick(); tick();
    chk("reset_wb", 64'(mem_to_wb), 64'd0);
    chk("reset_flags", {62'd0, misalign_err, bus_err}, 64'd0);
    chk("reset_req", 64'(dmem_req), 64'd0);
    rst = 1'b0;

    // ALU pass-through
    set_alu(32'h1234, 5'd5); #1;
    chk("alu_stall", 64'(stall_o), 64'd0);
    chk("alu_bypass", 64'(bp_mem), 64'h1234);
    chk("alu_req", 64'(dmem_req), 64'd0);
    tick();
    chk("alu_wb", 64'(mem_to_wb), wb(32'h1234, 5'd5, 1'b1));

    // Store with grant delayed three cycles
    set_st(32'h100, 32'hDEADBEEF); dmem_gnt = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("st_wait_req", {dmem_req, stall_o, dmem_we}, 64'b111);
      chk("st_wait_bus", {dmem_addr, dmem_wdata}, {32'h100, 32'hDEADBEEF});
      tick();
      chk("st_wait_wb_rw", 64'(mem_to_wb.reg_write), 64'd0);
    end
    dmem_gnt = 1'b1; #1;
    chk("st_gnt", {dmem_req, stall_o}, 64'b10);
    tick();
    dmem_gnt = 1'b0;
    chk("st_done_wb_rw", 64'(mem_to_wb.reg_write), 64'd0);
    set_nop(); #1;
    chk("st_back_idle", {dmem_req, stall_o}, 64'b00);

    // Store granted immediately: no stall
    set_st(32'h107, 32'h0BADF00D);
    set_st(32'h104, 32'h0BADF00D); dmem_gnt = 1'b1; #1;
    chk("st_fast", {dmem_req, stall_o, dmem_we}, 64'b101);
    tick();
    dmem_gnt = 1'b0;
    chk("st_fast_wb_rw", 64'(mem_to_wb.reg_write), 64'd0);

    // Load with immediate grant, data two cycles later
    set_ld(32'h200, 5'd7); dmem_gnt = 1'b1; #1;
    chk("ld_issue", {dmem_req, stall_o, dmem_we}, 64'b110);
    chk("ld_addr", 64'(dmem_addr), 64'h200);
    tick();
    dmem_gnt = 1'b0; #1;
    chk("ld_data_wait", {dmem_req, stall_o}, 64'b01);
    chk("ld_bubble", 64'(mem_to_wb.reg_write), 64'd0);
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D; #1;
    chk("ld_release", 64'(stall_o), 64'd0);
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    chk("ld_wb", 64'(mem_to_wb), wb(32'hCAFEF00D, 5'd7, 1'b1));
    set_alu(32'h55, 5'd3); #1;
    chk("ld_next_stall", 64'(stall_o), 64'd0);
    tick();
    chk("ld_next_wb", 64'(mem_to_wb), wb(32'h55, 5'd3, 1'b1));

    // Misaligned load: trapped, not issued
    set_ld(32'h202, 5'd9); #1;
    chk("mis_noreq", {dmem_req, stall_o}, 64'b00);
    tick();
    chk("mis_wb", 64'(mem_to_wb), wb(32'h0, 5'd9, 1'b1));
    chk("mis_flag", 64'(misalign_err), 64'd1);

    // Load granted but never answered: times out after four stalled cycles
    set_ld(32'h300, 5'd4); dmem_gnt = 1'b1; #1;
    chk("to_issue_stall", 64'(stall_o), 64'd1);
    tick();
    dmem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("to_stall", 64'(stall_o), 64'd1);
      tick();
      chk("to_no_buserr", 64'(bus_err), 64'd0);
    end
    chk("to_release", 64'(stall_o), 64'd0);
    tick();
    chk("to_buserr", 64'(bus_err), 64'd1);
    chk("to_wb", 64'(mem_to_wb), wb(32'h0, 5'd4, 1'b1));
    set_alu(32'h77, 5'd2); tick();
    chk("sticky_flags", {62'd0, misalign_err, bus_err}, 64'b11);

    // Reset while waiting for data; late rvalid must be ignored
    set_ld(32'h400, 5'd6); dmem_gnt = 1'b1; #1;
    tick();
    dmem_gnt = 1'b0; #1;
    chk("rst_in_data", 64'(stall_o), 64'd1);
    rst = 1'b1; set_nop();
    tick();
    rst = 1'b0;
    chk("rst_wb", 64'(mem_to_wb), 64'd0);
    chk("rst_flags", {62'd0, misalign_err, bus_err}, 64'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h11111111; #1;
    chk("rst_idle_outs", {dmem_req, stall_o, dmem_we}, 64'd0);
    chk("rst_idle_addr", 64'(dmem_addr), 64'd0);
    tick();
    dmem_rvalid = 1'b0;
    chk("rst_rvalid_ignored", 64'(mem_to_wb), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
